fcu_rr: RTL and testbench
=========================

Name: fcu_rr

Overview:
Parametrised credit-based flow control unit for one NoC router, built as the successor to the fixed 5-port fcu. It adds the following:
- per-output credit counters;
- per-output round-robin arbitration across all input ports;
- wormhole packet locking (an output is held by one input until that packet's tail flit);
- sticky error reporting.

It sits between the input buffers (which present head-of-queue requests) and the crossbar (driven from the select outputs).

Parameters:
NUM_PORTS, 5, number of router ports (inputs = outputs); index 0..4 = north, south, east, west, local.
PORT_W, 3, width of one destination port address; must satisfy 2**PORT_W >= NUM_PORTS.
CREDIT_DEPTH, 4, downstream buffer depth; reset and maximum value of every credit counter.
CNT_W, $clog2(CREDIT_DEPTH+1), credit counter width (derived).

Ports:
clk  input  1  router clock; all state updates on its rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid_i  input  NUM_PORTS  bit i: input i has a head flit requesting.
req_port_addr_i  input  NUM_PORTS*PORT_W  slice i: destination output of input i's flit.
req_tail_i  input  NUM_PORTS  bit i: input i's head flit is a packet tail (single-flit packets assert tail).
credit_en_i  input  NUM_PORTS  bit o: downstream of output o returned one credit this cycle.
grant_o  output  NUM_PORTS  bit i: input i's flit is forwarded this cycle; input pops on it.
out_valid_o  output  NUM_PORTS  bit o: output o carries a flit this cycle.
xbar_sel_o  output  NUM_PORTS*PORT_W  slice o: input index routed to output o; valid only when out_valid_o[o].
credit_cnt_o  output  NUM_PORTS*CNT_W  slice o: current credit count of output o.
err_o  output  1  sticky; set on credit overflow or an out-of-range address request.

Behaviour:
- Reset (rst_n low, asynchronous):
  - credit counters = CREDIT_DEPTH;
  - locks cleared;
  - round-robin pointers = NUM_PORTS-1, so input 0 has first priority;
  - err_o = 0.
  - While rst_n is low, grant_o, out_valid_o and xbar_sel_o are forced to 0 regardless of inputs.
  - Reset asserted mid-packet drops the lock; there is no recovery beyond the state reset.
- Grant decision is combinational (same cycle, zero latency) from the current inputs and registered state. State updates on the next rising edge of clk.
- Eligibility of input i for output o requires all of:
  - req_valid_i[i] = 1;
  - addr_i == o, with addr_i < NUM_PORTS;
  - credit_cnt[o] > 0, using the registered value (a credit returned this cycle cannot be spent this cycle);
  - output o is unlocked, or output o is locked to input i.
- Arbitration: per output, round-robin over eligible inputs.
  - Search starts at pointer+1, ascending, wrapping modulo NUM_PORTS.
  - Each input requests exactly one output, so at most one grant per input per cycle.
- On a grant of input i to output o:
  - grant_o[i] = 1, out_valid_o[o] = 1, xbar_sel_o[o] = i;
  - pointer[o] <= i;
  - credit[o] decrements.
- Lock state machine, per output: UNLOCKED / LOCKED(owner).
  - UNLOCKED -> LOCKED(i) on a grant with tail = 0.
  - LOCKED(i) -> UNLOCKED on a grant to i with tail = 1.
  - A grant with tail = 1 while UNLOCKED leaves the output UNLOCKED.
  - While LOCKED, other inputs are ineligible even if the owner is idle or the output has no credits.
- Credit counter per output:
  - next = cnt - grant + credit_en;
  - a simultaneous grant and credit_en leaves the count unchanged.
  - If cnt == CREDIT_DEPTH and credit_en arrives with no grant, the counter saturates at CREDIT_DEPTH and err_o is set.
  - The counter never underflows, because a grant requires cnt > 0.
- Out-of-range address (addr >= NUM_PORTS) with req_valid: never granted; sets err_o.
- err_o clears only on reset.

Decomposition:
- Package fcu_pkg holds:
  - the default NUM_PORTS;
  - the port index enum (PORT_NORTH = 0, PORT_SOUTH, PORT_EAST, PORT_WEST, PORT_LOCAL);
  - the lock state typedef.
- One sub-module: rr_arbiter.
  - Parametrised by N.
  - Inputs: request vector, pointer, optional lock-owner mask.
  - Outputs: one-hot grant, grant index, any-grant.
  - fcu_rr instantiates it once per output and owns the counters, locks and pointers.

Test Plan:
- Reset, then inputs 0..4 all request output LOCAL with tail = 1 on every flit for 4 cycles: grants go to inputs 0, 1, 2, 3 in order, then stop; credit_cnt[LOCAL] = 0.
- Input 1 sends a 3-flit packet to EAST (tail on the 3rd flit) while input 2 also requests EAST: input 1 holds EAST for 3 consecutive grants, then input 2 is granted; xbar_sel_o[EAST] = 1, 1, 1, 2.
- Drain credit[NORTH] to 0, then assert credit_en[NORTH] and a request in the same cycle: no grant that cycle, grant the next cycle; the count reads 1 and then 0.
- With credit[SOUTH] = 2, a grant and credit_en[SOUTH] in the same cycle: count stays 2. credit_en[SOUTH] at count 4 with no grant: count stays 4 and err_o = 1.
- Request with addr = 6: no grant and err_o = 1. Assert rst_n low mid-packet: outputs go to 0 immediately, counters read 4 and locks are cleared after release.

Source files
------------

// File: rtl/fcu_pkg.sv
// Shared types for the round-robin credit flow control unit: port naming and lock state.
package fcu_pkg;

    localparam int NUM_PORTS_DEF = 5;

    typedef enum logic [2:0] {
        PORT_NORTH = 3'd0,
        PORT_SOUTH = 3'd1,
        PORT_EAST  = 3'd2,
        PORT_WEST  = 3'd3,
        PORT_LOCAL = 3'd4
    } port_e;

    typedef enum logic {
        LK_UNLOCKED = 1'b0,
        LK_LOCKED   = 1'b1
    } lock_e;

endpackage

// File: rtl/fcu_rr_arbiter.sv
// Round-robin arbiter: first masked request strictly after the pointer, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 5,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic [N-1:0]  mask_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          any_o
);

    logic [N-1:0] masked;

    always_comb begin
        int idx;
        masked    = req_i & mask_i;
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!any_o && masked[idx]) begin
                any_o      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/fcu_rr.sv
// Credit-based flow control for one NoC router: per-output credits, round-robin
// arbitration, wormhole locking until the tail flit, and a sticky error flag.
module fcu_rr
    import fcu_pkg::*;
#(
    parameter int NUM_PORTS    = NUM_PORTS_DEF,
    parameter int PORT_W       = 3,
    parameter int CREDIT_DEPTH = 4,
    parameter int CNT_W        = $clog2(CREDIT_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS-1:0]          req_valid_i,
    input  logic [NUM_PORTS*PORT_W-1:0]   req_port_addr_i,
    input  logic [NUM_PORTS-1:0]          req_tail_i,
    input  logic [NUM_PORTS-1:0]          credit_en_i,
    output logic [NUM_PORTS-1:0]          grant_o,
    output logic [NUM_PORTS-1:0]          out_valid_o,
    output logic [NUM_PORTS*PORT_W-1:0]   xbar_sel_o,
    output logic [NUM_PORTS*CNT_W-1:0]    credit_cnt_o,
    output logic                          err_o
);

    logic [CNT_W-1:0]     credit_q [NUM_PORTS];
    logic [CNT_W-1:0]     credit_d [NUM_PORTS];
    lock_e                lock_q   [NUM_PORTS];
    lock_e                lock_d   [NUM_PORTS];
    logic [PORT_W-1:0]    owner_q  [NUM_PORTS];
    logic [PORT_W-1:0]    owner_d  [NUM_PORTS];
    logic [PORT_W-1:0]    ptr_q    [NUM_PORTS];
    logic [PORT_W-1:0]    ptr_d    [NUM_PORTS];
    logic                 err_q, err_d;

    logic [PORT_W-1:0]    addr     [NUM_PORTS];
    logic [NUM_PORTS-1:0] req_m    [NUM_PORTS];
    logic [NUM_PORTS-1:0] mask_m   [NUM_PORTS];
    logic [NUM_PORTS-1:0] gnt_m    [NUM_PORTS];
    logic [PORT_W-1:0]    gidx     [NUM_PORTS];
    logic [NUM_PORTS-1:0] any_g;

    // Out-of-range addresses never match any output index, so they are never requested.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) addr[i] = req_port_addr_i[i*PORT_W +: PORT_W];
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                req_m[o][i]  = req_valid_i[i] && (addr[i] == PORT_W'(o)) && (credit_q[o] != '0);
                mask_m[o][i] = (lock_q[o] == LK_UNLOCKED) || (owner_q[o] == PORT_W'(i));
            end
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
        rr_arbiter #(.N(NUM_PORTS), .IW(PORT_W)) u_arb (
            .req_i     (req_m[o]),
            .ptr_i     (ptr_q[o]),
            .mask_i    (mask_m[o]),
            .gnt_o     (gnt_m[o]),
            .gnt_idx_o (gidx[o]),
            .any_o     (any_g[o])
        );
    end

    always_comb begin
        grant_o      = '0;
        out_valid_o  = '0;
        xbar_sel_o   = '0;
        credit_cnt_o = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            credit_cnt_o[o*CNT_W +: CNT_W] = credit_q[o];
            if (rst_n && any_g[o]) begin
                grant_o                      = grant_o | gnt_m[o];
                out_valid_o[o]               = 1'b1;
                xbar_sel_o[o*PORT_W +: PORT_W] = gidx[o];
            end
        end
    end

    assign err_o = err_q;

    always_comb begin
        err_d = err_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (req_valid_i[i] && int'(addr[i]) >= NUM_PORTS) err_d = 1'b1;
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            credit_d[o] = credit_q[o];
            lock_d[o]   = lock_q[o];
            owner_d[o]  = owner_q[o];
            ptr_d[o]    = ptr_q[o];
            if (any_g[o] && !credit_en_i[o]) begin
                credit_d[o] = credit_q[o] - 1'b1;
            end else if (!any_g[o] && credit_en_i[o]) begin
                if (credit_q[o] == CNT_W'(CREDIT_DEPTH)) err_d = 1'b1;
                else                                      credit_d[o] = credit_q[o] + 1'b1;
            end
            if (any_g[o]) begin
                ptr_d[o]   = gidx[o];
                owner_d[o] = gidx[o];
                lock_d[o]  = |(gnt_m[o] & req_tail_i) ? LK_UNLOCKED : LK_LOCKED;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                credit_q[o] <= CNT_W'(CREDIT_DEPTH);
                lock_q[o]   <= LK_UNLOCKED;
                owner_q[o]  <= '0;
                ptr_q[o]    <= PORT_W'(NUM_PORTS - 1);
            end
            err_q <= 1'b0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                credit_q[o] <= credit_d[o];
                lock_q[o]   <= lock_d[o];
                owner_q[o]  <= owner_d[o];
                ptr_q[o]    <= ptr_d[o];
            end
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_fcu_rr.sv
// Scoreboard bench for fcu_rr: a packet-level reference model predicts each cycle's
// outputs, a negedge monitor compares them; directed scenarios add fixed expectations.
module tb_fcu_rr;

    localparam int N  = 5;
    localparam int PW = 3;
    localparam int D  = 4;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*PW-1:0] req_addr = '0;
    logic [N-1:0]    req_tail = '0;
    logic [N-1:0]    credit_en = '0;
    logic [N-1:0]    grant, out_valid;
    logic [N*PW-1:0] xbar_sel;
    logic [N*CW-1:0] credit_cnt;
    logic            err;

    fcu_rr #(.NUM_PORTS(N), .PORT_W(PW), .CREDIT_DEPTH(D)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid_i     (req_valid),
        .req_port_addr_i (req_addr),
        .req_tail_i      (req_tail),
        .credit_en_i     (credit_en),
        .grant_o         (grant),
        .out_valid_o     (out_valid),
        .xbar_sel_o      (xbar_sel),
        .credit_cnt_o    (credit_cnt),
        .err_o           (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]    gnt;
        logic [N-1:0]    ov;
        logic [N*PW-1:0] sel;
        logic [N*CW-1:0] cnt;
        logic            err;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    // reference model state: plain integers per output
    int m_cred[N];
    int m_ptr[N];
    int m_own[N];
    bit m_lock[N];
    bit m_err;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N*PW-1:0] pa(input int a0, a1, a2, a3, a4);
        logic [N*PW-1:0] r;
        r = {PW'(a4), PW'(a3), PW'(a2), PW'(a1), PW'(a0)};
        return r;
    endfunction

    function automatic int cnt_of(input int o);
        logic [N*CW-1:0] v;
        v = credit_cnt;
        return int'(v[o*CW +: CW]);
    endfunction

    function automatic int sel_of(input int o);
        logic [N*PW-1:0] v;
        v = xbar_sel;
        return int'(v[o*PW +: PW]);
    endfunction

    task automatic model_reset();
        for (int o = 0; o < N; o++) begin
            m_cred[o] = D; m_ptr[o] = N - 1; m_own[o] = 0; m_lock[o] = 0;
        end
        m_err = 0;
    endtask

    // One clock of stimulus; r is the rst_n level held for this cycle.
    task automatic cycle(input logic r, input logic [N-1:0] v, input logic [N*PW-1:0] a,
                         input logic [N-1:0] t, input logic [N-1:0] c);
        exp_t e;
        int   gi[N];
        @(posedge clk);
        #2;
        rst_n = r; req_valid = v; req_addr = a; req_tail = t; credit_en = c;
        e = '0;
        if (!r) begin
            model_reset();
        end else begin
            for (int o = 0; o < N; o++) begin
                gi[o] = -1;
                if (m_cred[o] > 0) begin
                    for (int k = 1; k <= N && gi[o] < 0; k++) begin
                        int i;
                        i = (m_ptr[o] + k) % N;
                        if (v[i] && int'(a[i*PW +: PW]) == o && (!m_lock[o] || m_own[o] == i))
                            gi[o] = i;
                    end
                end
            end
        end
        for (int o = 0; o < N; o++) e.cnt[o*CW +: CW] = CW'(m_cred[o]);
        e.err = m_err;
        if (r) begin
            for (int o = 0; o < N; o++) begin
                if (gi[o] >= 0) begin
                    e.gnt[gi[o]] = 1'b1;
                    e.ov[o] = 1'b1;
                    e.sel[o*PW +: PW] = PW'(gi[o]);
                end
            end
            for (int i = 0; i < N; i++)
                if (v[i] && int'(a[i*PW +: PW]) >= N) m_err = 1;
            for (int o = 0; o < N; o++) begin
                int g;
                g = (gi[o] >= 0) ? 1 : 0;
                if (c[o] && g == 0 && m_cred[o] == D) m_err = 1;
                else m_cred[o] = m_cred[o] - g + int'(c[o]);
                if (g == 1) begin
                    m_ptr[o]  = gi[o];
                    m_own[o]  = gi[o];
                    m_lock[o] = !t[gi[o]];
                end
            end
        end
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("grant", int'(grant), int'(e.gnt));
            chk("out_valid", int'(out_valid), int'(e.ov));
            chk("credit_cnt", int'(credit_cnt), int'(e.cnt));
            chk("err", int'(err), int'(e.err));
            for (int o = 0; o < N; o++)
                if (e.ov[o]) chk("xbar_sel", sel_of(o), int'(e.sel[o*PW +: PW]));
        end
    end

    initial begin
        logic [N*PW-1:0] a;
        logic [N-1:0] v, t, c;
        model_reset();

        // all inputs to LOCAL: 0,1,2,3 then out of credit
        cycle(0, '0, '0, '0, '0);
        #1; chk("reset_cnt_local", cnt_of(4), D);
        chk("reset_err", int'(err), 0);
        for (int k = 0; k < 4; k++) begin
            cycle(1, 5'b11111, pa(4, 4, 4, 4, 4), 5'b11111, '0);
            #1; chk("rr_local_grant", int'(grant), 1 << k);
        end
        cycle(1, 5'b11111, pa(4, 4, 4, 4, 4), 5'b11111, '0);
        #1; chk("local_drained_grant", int'(grant), 0);
        chk("local_drained_cnt", cnt_of(4), 0);
        repeat (4) cycle(1, '0, '0, '0, 5'b10000);

        // wormhole: input 1 holds EAST for 3 flits, then input 2
        a = pa(0, 2, 2, 0, 0);
        cycle(1, 5'b00110, a, 5'b00100, '0); #1; chk("east_sel0", sel_of(2), 1);
        cycle(1, 5'b00110, a, 5'b00100, '0); #1; chk("east_sel1", sel_of(2), 1);
        cycle(1, 5'b00110, a, 5'b00110, '0); #1; chk("east_sel2", sel_of(2), 1);
        cycle(1, 5'b00100, a, 5'b00100, '0); #1; chk("east_sel3", sel_of(2), 2);
        repeat (4) cycle(1, '0, '0, '0, 5'b00100);

        // NORTH: returned credit not spendable in the same cycle
        repeat (4) cycle(1, 5'b00001, pa(0, 0, 0, 0, 0), 5'b00001, '0);
        cycle(1, 5'b00001, pa(0, 0, 0, 0, 0), 5'b00001, 5'b00001);
        #1; chk("north_zero_grant", int'(grant), 0);
        chk("north_zero_cnt", cnt_of(0), 0);
        cycle(1, 5'b00001, pa(0, 0, 0, 0, 0), 5'b00001, '0);
        #1; chk("north_late_grant", int'(grant), 1);
        chk("north_cnt1", cnt_of(0), 1);
        cycle(1, '0, '0, '0, 5'b00001);
        #1; chk("north_cnt0", cnt_of(0), 0);

        // SOUTH: simultaneous grant+credit, then overflow
        a = pa(0, 0, 0, 1, 0);
        repeat (2) cycle(1, 5'b01000, a, 5'b01000, '0);
        cycle(1, 5'b01000, a, 5'b01000, 5'b00010);
        cycle(1, '0, '0, '0, '0); #1; chk("south_hold_cnt", cnt_of(1), 2);
        repeat (2) cycle(1, '0, '0, '0, 5'b00010);
        cycle(1, '0, '0, '0, 5'b00010);
        cycle(1, '0, '0, '0, '0); #1; chk("south_sat_cnt", cnt_of(1), D);
        chk("south_ovf_err", int'(err), 1);

        // out-of-range address
        cycle(0, '0, '0, '0, '0);
        cycle(1, 5'b00001, pa(6, 0, 0, 0, 0), 5'b00001, '0);
        #1; chk("oor_grant", int'(grant), 0);
        cycle(1, '0, '0, '0, '0); #1; chk("oor_err", int'(err), 1);

        // reset mid-packet drops the WEST lock
        cycle(0, '0, '0, '0, '0);
        cycle(1, 5'b01000, pa(0, 0, 0, 3, 0), 5'b00000, '0);
        cycle(1, 5'b10000, pa(0, 0, 0, 0, 3), 5'b10000, '0);
        #1; chk("west_locked", int'(grant), 0);
        cycle(0, 5'b11000, pa(0, 0, 0, 3, 3), 5'b10000, '0);
        #1; chk("rst_grant", int'(grant), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_sel", int'(xbar_sel), 0);
        chk("rst_cnt", cnt_of(3), D);
        cycle(1, 5'b10000, pa(0, 0, 0, 0, 3), 5'b10000, '0);
        #1; chk("west_unlocked", int'(grant), 5'b10000);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                a[i*PW +: PW] = ($urandom_range(0, 15) < 14) ? PW'($urandom_range(0, 4))
                                                            : PW'($urandom_range(5, 7));
                c[i] = ($urandom_range(0, 3) == 0);
            end
            v = N'($urandom);
            t = N'($urandom);
            cycle(($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1, v, a, t, c);
        end
        cycle(1, '0, '0, '0, '0);

        for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
        @(posedge clk);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
